// File: rtl/lp_arith_issue.sv
// rtl/lp_arith_issue.sv - FIFO-buffered issue/capture stage around a power-gated arithmetic unit.
// Optional completed-op counter built only when LP_ARITH_ISSUE_STATS_EN is defined.
module lp_arith_issue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_op,
    input  logic [2*WIDTH-1:0]   alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [1:0]           out_op,
    output logic [15:0]          ops_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * WIDTH + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [1:0]    OP_IDLE  = 2'b11;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [1:0]       r_s1_op;

    logic             r_out_valid;
    logic [2*WIDTH-1:0] r_out_result;
    logic [1:0]       r_out_op;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_s2_free;
    logic             w_s2_cap;
    logic [EW-1:0]    w_head;

    // in_ready comes from the registered count, so a same-cycle pop never reopens it early.
    assign in_ready  = (r_count != FULL_CNT);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & (in_op != OP_IDLE);
    assign w_s2_free = ~r_out_valid | out_ready;
    assign w_pop     = (r_count != '0) & (~r_s1_valid | w_s2_free);
    assign w_s2_cap  = r_s1_valid & w_s2_free;
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Idle S1 parks operands at zero and op at NOP so the unit sees no toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_IDLE;
        end else if (w_pop) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= w_head[EW-1 -: 2];
            r_s1_a     <= w_head[2*WIDTH-1 -: WIDTH];
            r_s1_b     <= w_head[WIDTH-1:0];
        end else if (w_s2_cap) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_op     <= 2'b00;
        end else if (w_s2_cap) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_op     <= r_s1_op;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

`ifdef LP_ARITH_ISSUE_STATS_EN
    logic [15:0] r_ops_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ops_done <= 16'h0;
        end else if (r_out_valid & out_ready) begin
            r_ops_done <= r_ops_done + 16'h1;
        end
    end

    assign ops_done = r_ops_done;
`else
    assign ops_done = 16'h0;
`endif

    assign alu_a      = r_s1_a;
    assign alu_b      = r_s1_b;
    assign alu_op     = r_s1_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_op     = r_out_op;

endmodule

// File: tb/tb_lp_arith_issue.sv
// tb/tb_lp_arith_issue.sv - self-checking bench for lp_arith_issue with a behavioural arithmetic unit.
module tb_lp_arith_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [1:0]  out_op;
    logic [15:0] ops_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    lp_arith_issue #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .ops_done(ops_done)
    );

    function automatic logic [15:0] ref_calc(input logic [1:0] op, input int a, input int b);
        int r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    always_comb begin
        alu_result = ref_calc(alu_op, int'(alu_a), int'(alu_b));
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) @(negedge clk);
        n_tests++; if (alu_op !== 2'b11) begin n_fail++; $display("FAIL reset_alu_op got %b want 11", alu_op); end
        n_tests++; if (alu_a !== 8'h0 || alu_b !== 8'h0) begin n_fail++; $display("FAIL reset_alu_ab got %h/%h want 00/00", alu_a, alu_b); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_result !== 16'h0 || out_op !== 2'b00) begin n_fail++; $display("FAIL reset_out got %h/%b want 0000/00", out_result, out_op); end
        n_tests++; if (ops_done !== 16'h0) begin n_fail++; $display("FAIL reset_ops_done got %h want 0000", ops_done); end
    endtask

    task automatic test_single();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3; in_op = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_n got %b want 0", out_valid); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_n1 got %b want 0", out_valid); end
        n_tests++; if (alu_op !== 2'b00 || alu_a !== 8'd5 || alu_b !== 8'd3) begin n_fail++; $display("FAIL single_issue got op=%b a=%0d b=%0d want 00/5/3", alu_op, alu_a, alu_b); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat_n2 got %b want 1", out_valid); end
        n_tests++; if (out_result !== 16'h0008 || out_op !== 2'b00) begin n_fail++; $display("FAIL single_result got %h/%b want 0008/00", out_result, out_op); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || alu_op !== 2'b11) begin n_fail++; $display("FAIL single_after got valid=%b op=%b want 0/11", out_valid, alu_op); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t_op[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [7:0]  t_a[4]  = '{8'd3, 8'd255, 8'd7, 8'd1};
        logic [7:0]  t_b[4]  = '{8'd5, 8'd255, 8'd9, 8'd1};
        logic [15:0] w_res[3] = '{16'hFFFE, 16'hFE01, 16'h0002};
        logic [1:0]  w_op[3]  = '{2'b01, 2'b10, 2'b00};
        logic [15:0] got_res[$];
        logic [1:0]  got_op[$];
        int          got_cyc[$];
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got_res.push_back(out_result); got_op.push_back(out_op); got_cyc.push_back(c);
            end
            if (c < 4) begin
                in_valid = 1'b1; in_op = t_op[c]; in_a = t_a[c]; in_b = t_b[c];
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        n_tests++;
        if (got_res.size() != 3) begin
            n_fail++; $display("FAIL b2b_count got %0d want 3", got_res.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++; if (got_res[i] !== w_res[i] || got_op[i] !== w_op[i]) begin n_fail++; $display("FAIL b2b_result%0d got %h/%b want %h/%b", i, got_res[i], got_op[i], w_res[i], w_op[i]); end
            end
            n_tests++; if (got_cyc[1] != got_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_consecutive got cycles %0d,%0d want adjacent", got_cyc[0], got_cyc[1]); end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int drained = 0;
        logic [17:0] snap;
        logic [17:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!in_ready) break;
            in_valid = 1'b1; in_op = 2'b00; in_a = 8'($urandom); in_b = 8'($urandom);
            exp_q.push_back({2'b00, ref_calc(2'b00, int'(in_a), int'(in_b))});
            acc++;
        end
        in_valid = 1'b0;
        n_tests++; if (acc != 6) begin n_fail++; $display("FAIL bp_capacity got %0d want 6", acc); end
        snap = {alu_op, alu_a, alu_b};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if ({alu_op, alu_a, alu_b} !== snap) begin n_fail++; $display("FAIL bp_alu_stable got %h want %h", {alu_op, alu_a, alu_b}, snap); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra got %h want none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_op, out_result} !== e) begin n_fail++; $display("FAIL bp_drain got %h want %h", {out_op, out_result}, e); end
                end
                drained++;
            end
            @(negedge clk);
        end
        n_tests++; if (drained != 6) begin n_fail++; $display("FAIL bp_drained got %0d want 6", drained); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 2'b10; in_a = 8'(i + 2); in_b = 8'd3;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 2'b10) begin n_fail++; $display("FAIL rmid_setup got valid=%b op=%b want 1/10", out_valid, alu_op); end
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_flags got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        n_tests++; if (alu_op !== 2'b11 || alu_a !== 8'h0 || alu_b !== 8'h0) begin n_fail++; $display("FAIL rmid_alu got %b/%h/%h want 11/00/00", alu_op, alu_a, alu_b); end
        n_tests++; if (out_result !== 16'h0 || out_op !== 2'b00) begin n_fail++; $display("FAIL rmid_out got %h/%b want 0000/00", out_result, out_op); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_tests++; if (stale != 0) begin n_fail++; $display("FAIL rmid_stale got %0d results want 0", stale); end
    endtask

    task automatic test_stats();
        logic [15:0] want;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c < 5) begin
                in_valid = 1'b1; in_op = 2'b00; in_a = 8'(c); in_b = 8'd1;
            end else begin
                in_valid = 1'b0;
            end
        end
`ifdef LP_ARITH_ISSUE_STATS_EN
        want = 16'd5;
`else
        want = 16'd0;
`endif
        n_tests++; if (ops_done !== want) begin n_fail++; $display("FAIL stats_ops_done got %0d want %0d", ops_done, want); end
    endtask

    task automatic test_random();
        int          hs = 0;
        logic [15:0] want_ops;
        logic [17:0] e;
        do_reset();
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
`ifdef LP_ARITH_ISSUE_STATS_EN
            want_ops = 16'(hs);
`else
            want_ops = 16'h0;
`endif
            n_tests++; if (ops_done !== want_ops) begin n_fail++; $display("FAIL rand_ops_done got %0d want %0d", ops_done, want_ops); end
            n_tests++; if (alu_op === 2'b11 && (alu_a !== 8'h0 || alu_b !== 8'h0)) begin n_fail++; $display("FAIL rand_gating got %h/%h want 00/00", alu_a, alu_b); end
            if (in_valid && in_ready && in_op != 2'b11) begin
                exp_q.push_back({in_op, ref_calc(in_op, int'(in_a), int'(in_b))});
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra got %h want none", {out_op, out_result});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_op, out_result} !== e) begin n_fail++; $display("FAIL rand_result got %h want %h", {out_op, out_result}, e); end
                end
                hs++;
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
